cell_mem_arbiter: RTL and testbench

CELL_MEM_ARBITER -- requirements
Module: cell_mem_arbiter

---
 rtl/cell_mem_arbiter_pkg.sv | 13 +
 rtl/cell_mem_arbiter_read_tag_pipe.sv | 29 ++
 rtl/cell_mem_arbiter.sv | 119 +++++++++++
 tb/tb_cell_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_mem_arbiter_pkg.sv
// Shared types for the cell-memory arbiter: requester identifiers carried
// alongside grants and through the read-return tag pipeline.
`timescale 1ns/1ps
package cell_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      REQ_NONE   = 2'd0,
      REQ_RENDER = 2'd1,
      REQ_LOGIC  = 2'd2,
      REQ_EDIT   = 2'd3
   } req_id_t;

endpackage

// File: rtl/cell_mem_arbiter_read_tag_pipe.sv
// Requester-ID shift register that follows each read through the memory's
// fixed latency, so returning data can be steered to its owner.
`timescale 1ns/1ps
module read_tag_pipe
   import cell_mem_arbiter_pkg::*;
#(
   parameter int READ_LAT = 2
) (
   input  logic    clk_in,
   input  logic    clear,
   input  req_id_t tag_push,
   output req_id_t tag_pop
);

   req_id_t stage [READ_LAT];

   always_ff @(posedge clk_in) begin
      // NOTE: the stages are cleared on reset, unlike a data RAM, because a stale tag would fire a spurious rvalid.
      if (clear) begin
         for (int i = 0; i < READ_LAT; i++) stage[i] <= REQ_NONE;
      end else begin
         stage[0] <= tag_push;
         for (int i = 1; i < READ_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_pop = stage[READ_LAT-1];

endmodule

// File: rtl/cell_mem_arbiter.sv
// Single-port cell-memory arbiter: render has strict priority, logic and edit
// alternate round-robin; read data is steered back by a requester-ID tag pipe.
`timescale 1ns/1ps
module cell_mem_arbiter
   import cell_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              render_req_in,
   input  logic [ADDR_W-1:0] render_addr_in,
   input  logic              logic_req_in,
   input  logic              logic_we_in,
   input  logic [ADDR_W-1:0] logic_addr_in,
   input  logic [DATA_W-1:0] logic_wdata_in,
   input  logic              edit_req_in,
   input  logic              edit_we_in,
   input  logic [ADDR_W-1:0] edit_addr_in,
   input  logic [DATA_W-1:0] edit_wdata_in,
   output logic              render_gnt_out,
   output logic              logic_gnt_out,
   output logic              edit_gnt_out,
   output logic              render_rvalid_out,
   output logic              logic_rvalid_out,
   output logic              edit_rvalid_out,
   output logic [DATA_W-1:0] rdata_out,
   output logic              mem_en_out,
   output logic              mem_we_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [DATA_W-1:0] mem_wdata_out,
   input  logic [DATA_W-1:0] mem_rdata_in
);

   req_id_t           winner;
   logic              rr_logic_q;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   req_id_t           mem_tag_q;
   req_id_t           ret_tag;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      winner    = REQ_NONE;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (!rst_in) begin
         if (render_req_in)                                  winner = REQ_RENDER;
         else if (logic_req_in && (!edit_req_in || rr_logic_q)) winner = REQ_LOGIC;
         else if (edit_req_in)                               winner = REQ_EDIT;
      end
      case (winner)
         REQ_RENDER: sel_addr = render_addr_in;
         REQ_LOGIC: begin
            sel_we    = logic_we_in;
            sel_addr  = logic_addr_in;
            sel_wdata = logic_wdata_in;
         end
         REQ_EDIT: begin
            sel_we    = edit_we_in;
            sel_addr  = edit_addr_in;
            sel_wdata = edit_wdata_in;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst_in) begin
         rr_logic_q  <= 1'b1;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_tag_q   <= REQ_NONE;
      end else begin
         mem_en_q    <= (winner != REQ_NONE);
         mem_we_q    <= sel_we;
         mem_addr_q  <= sel_addr;
         mem_wdata_q <= sel_wdata;
         mem_tag_q   <= (winner != REQ_NONE && !sel_we) ? winner : REQ_NONE;
         if (winner == REQ_LOGIC)     rr_logic_q <= 1'b0;
         else if (winner == REQ_EDIT) rr_logic_q <= 1'b1;
      end
   end

   // The tag enters alongside the address, so it emerges as the data arrives.
   read_tag_pipe #(.READ_LAT(READ_LAT)) u_tag_pipe (
      .clk_in   (clk_in),
      .clear    (rst_in),
      .tag_push (mem_tag_q),
      .tag_pop  (ret_tag)
   );

   assign render_gnt_out    = (winner == REQ_RENDER);
   assign logic_gnt_out     = (winner == REQ_LOGIC);
   assign edit_gnt_out      = (winner == REQ_EDIT);

   // Reset masks the port immediately rather than one edge later.
   assign mem_en_out        = mem_en_q & ~rst_in;
   assign mem_we_out        = mem_we_q & ~rst_in;
   assign mem_addr_out      = rst_in ? '0 : mem_addr_q;
   assign mem_wdata_out     = rst_in ? '0 : mem_wdata_q;

   assign render_rvalid_out = (ret_tag == REQ_RENDER) & ~rst_in;
   assign logic_rvalid_out  = (ret_tag == REQ_LOGIC)  & ~rst_in;
   assign edit_rvalid_out   = (ret_tag == REQ_EDIT)   & ~rst_in;
   assign rdata_out         = mem_rdata_in;

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Bench for cell_mem_arbiter: three builds (READ_LAT 2, 1, 4) share stimulus;
// the latency-2 build is also checked every cycle against a scoreboard model.
`timescale 1ns/1ps
module tb_cell_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_in = 1'b1;
   logic        render_req = 1'b0, logic_req = 1'b0, edit_req = 1'b0;
   logic        logic_we = 1'b0, edit_we = 1'b0;
   logic [15:0] render_addr = '0, logic_addr = '0, edit_addr = '0;
   logic [7:0]  logic_wdata = '0, edit_wdata = '0;

   logic        r_gnt [3], l_gnt [3], e_gnt [3];
   logic        r_rv [3], l_rv [3], e_rv [3];
   logic [7:0]  rdata_v [3];
   logic        mem_en_v [3], mem_we_v [3];
   logic [15:0] mem_addr_v [3];
   logic [7:0]  mem_wdata_v [3], mem_rdata_v [3];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : (g == 1) ? 1 : 4;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- DUT instances with behavioural memories ----------------
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      logic [7:0] mem [0:65535];
      logic [7:0] pipe [L];

      initial for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));

      always @(posedge clk) begin
         if (mem_en_v[g] && mem_we_v[g]) mem[mem_addr_v[g]] <= mem_wdata_v[g];
         for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
         pipe[0] <= (mem_en_v[g] && !mem_we_v[g]) ? mem[mem_addr_v[g]] : 8'hEE;
      end
      assign mem_rdata_v[g] = pipe[L-1];

      cell_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .READ_LAT(L)) u_dut (
         .clk_in            (clk),
         .rst_in            (rst_in),
         .render_req_in     (render_req),
         .render_addr_in    (render_addr),
         .logic_req_in      (logic_req),
         .logic_we_in       (logic_we),
         .logic_addr_in     (logic_addr),
         .logic_wdata_in    (logic_wdata),
         .edit_req_in       (edit_req),
         .edit_we_in        (edit_we),
         .edit_addr_in      (edit_addr),
         .edit_wdata_in     (edit_wdata),
         .render_gnt_out    (r_gnt[g]),
         .logic_gnt_out     (l_gnt[g]),
         .edit_gnt_out      (e_gnt[g]),
         .render_rvalid_out (r_rv[g]),
         .logic_rvalid_out  (l_rv[g]),
         .edit_rvalid_out   (e_rv[g]),
         .rdata_out         (rdata_v[g]),
         .mem_en_out        (mem_en_v[g]),
         .mem_we_out        (mem_we_v[g]),
         .mem_addr_out      (mem_addr_v[g]),
         .mem_wdata_out     (mem_wdata_v[g]),
         .mem_rdata_in      (mem_rdata_v[g])
      );
   end

   // ---------------- Scoreboard model of the latency-2 build ----------------
   typedef struct {
      int         due;
      int         who;
      logic [7:0] data;
   } rd_t;

   rd_t         rdq [$];
   logic [7:0]  ref_mem [0:65535];
   bit          ptr_logic = 1'b1;
   logic        exp_en = 1'b0, exp_we = 1'b0;
   logic [15:0] exp_addr = '0;
   logic [7:0]  exp_wdata = '0;

   initial for (int a = 0; a < 65536; a++) ref_mem[a] = pat(16'(a));

   always @(negedge clk) begin : p_model
      int          win;
      logic [2:0]  exp_rv;
      logic [7:0]  exp_rd;
      logic        w_we;
      logic [15:0] w_addr;
      logic [7:0]  w_wd;
      if (rst_in) begin
         check("rst_gnt", {29'd0, r_gnt[0], l_gnt[0], e_gnt[0]}, 32'd0);
         check("rst_rvalid", {29'd0, r_rv[0], l_rv[0], e_rv[0]}, 32'd0);
         check("rst_mem_port", {6'd0, mem_en_v[0], mem_we_v[0], mem_addr_v[0], mem_wdata_v[0]}, 32'd0);
         ptr_logic = 1'b1;
         rdq.delete();
         exp_en = 1'b0;
         exp_we = 1'b0;
      end else begin
         if (render_req)                 win = 1;
         else if (logic_req && edit_req) win = ptr_logic ? 2 : 3;
         else if (logic_req)             win = 2;
         else if (edit_req)              win = 3;
         else                            win = 0;
         check("gnt", {29'd0, r_gnt[0], l_gnt[0], e_gnt[0]},
               {29'd0, win == 1, win == 2, win == 3});

         if (!exp_en)
            check("mem_idle", {30'd0, mem_en_v[0], mem_we_v[0]}, 32'd0);
         else if (exp_we)
            check("mem_write", {6'd0, mem_en_v[0], mem_we_v[0], mem_addr_v[0], mem_wdata_v[0]},
                  {6'd0, 1'b1, 1'b1, exp_addr, exp_wdata});
         else
            check("mem_read", {14'd0, mem_en_v[0], mem_we_v[0], mem_addr_v[0]},
                  {14'd0, 1'b1, 1'b0, exp_addr});

         exp_rv = 3'b000;
         exp_rd = 8'h00;
         foreach (rdq[k]) if (rdq[k].due == cyc) begin
            exp_rv = 3'b100 >> (rdq[k].who - 1);
            exp_rd = rdq[k].data;
         end
         while (rdq.size() > 0 && rdq[0].due <= cyc) void'(rdq.pop_front());
         check("rvalid", {29'd0, r_rv[0], l_rv[0], e_rv[0]}, {29'd0, exp_rv});
         if (exp_rv != 3'b000) check("rdata", {24'd0, rdata_v[0]}, {24'd0, exp_rd});

         w_we = 1'b0; w_addr = '0; w_wd = '0;
         if (win == 1) w_addr = render_addr;
         if (win == 2) begin w_we = logic_we; w_addr = logic_addr; w_wd = logic_wdata; end
         if (win == 3) begin w_we = edit_we;  w_addr = edit_addr;  w_wd = edit_wdata;  end
         exp_en = (win != 0);
         exp_we = w_we;
         exp_addr = w_addr;
         exp_wdata = w_wd;
         if (win != 0) begin
            if (w_we) ref_mem[w_addr] = w_wd;
            else      rdq.push_back('{cyc + 1 + 2, win, ref_mem[w_addr]});
         end
         if (win == 2) ptr_logic = 1'b0;
         if (win == 3) ptr_logic = 1'b1;
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic sample();
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      render_req = 1'b0; logic_req = 1'b0; edit_req = 1'b0;
      logic_we = 1'b0; edit_we = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      idle();
      for (int i = 0; i < n; i++) next();
   endtask

   typedef struct {
      bit         r, l, e;
      logic [2:0] exp;
   } vec_t;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      vec_t tbl [13];
      bit   found;
      bit   l_pend, e_pend;

      tbl = '{'{0,1,1,3'b010}, '{0,1,1,3'b001}, '{0,1,1,3'b010}, '{1,1,1,3'b100},
              '{0,1,1,3'b001}, '{0,1,0,3'b010}, '{0,1,0,3'b010}, '{0,1,1,3'b001},
              '{1,0,0,3'b100}, '{0,0,0,3'b000}, '{0,0,1,3'b001}, '{0,1,1,3'b010},
              '{0,1,1,3'b001}};

      // Reset held for three cycles; the model checks every output is zero.
      for (int i = 0; i < 3; i++) next();
      rst_in = 1'b0;

      // Arbitration table (reads only), starting from the post-reset pointer.
      for (int i = 0; i < 13; i++) begin
         render_req = tbl[i].r; logic_req = tbl[i].l; edit_req = tbl[i].e;
         render_addr = 16'(i); logic_addr = 16'h0100 + 16'(i); edit_addr = 16'h0200 + 16'(i);
         sample();
         check($sformatf("tbl_gnt[%0d]", i), {29'd0, r_gnt[0], l_gnt[0], e_gnt[0]}, {29'd0, tbl[i].exp});
         next();
      end
      idle_cycles(6);

      // Render reads 0..7 back-to-back on all three latency builds.
      for (int j = 0; j < 14; j++) begin
         render_req = (j < 8);
         render_addr = 16'(j);
         sample();
         check($sformatf("render_gnt[%0d]", j), {31'd0, r_gnt[0]}, {31'd0, j < 8});
         for (int g = 0; g < 3; g++) begin
            int d;
            d = j - 1 - lat_of(g);
            check($sformatf("lat%0d_rvalid[%0d]", lat_of(g), j), {31'd0, r_rv[g]},
                  {31'd0, (d >= 0 && d < 8)});
            if (d >= 0 && d < 8)
               check($sformatf("lat%0d_rdata[%0d]", lat_of(g), j), {24'd0, rdata_v[g]},
                     {24'd0, pat(16'(d))});
         end
         next();
      end
      idle_cycles(4);

      // Logic and edit contending continuously: L,E,L,E...
      logic_req = 1'b1; edit_req = 1'b1; logic_addr = 16'h0040; edit_addr = 16'h0080;
      for (int i = 0; i < 8; i++) begin
         sample();
         check($sformatf("rr_alt[%0d]", i), {29'd0, r_gnt[0], l_gnt[0], e_gnt[0]},
               (i % 2 == 0) ? 32'd2 : 32'd1);
         next();
      end

      // Render steals five cycles; the pointer must not move.
      render_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         render_addr = 16'h0300 + 16'(i);
         sample();
         check($sformatf("render_steal[%0d]", i), {29'd0, r_gnt[0], l_gnt[0], e_gnt[0]}, 32'd4);
         next();
      end
      render_req = 1'b0;
      sample();
      check("ptr_after_render_l", {29'd0, r_gnt[0], l_gnt[0], e_gnt[0]}, 32'd2);
      next();
      sample();
      check("ptr_after_render_e", {29'd0, r_gnt[0], l_gnt[0], e_gnt[0]}, 32'd1);
      next();
      idle_cycles(6);

      // Edit writes 0x5A to 0x0010, logic reads it back the next cycle.
      edit_req = 1'b1; edit_we = 1'b1; edit_addr = 16'h0010; edit_wdata = 8'h5A;
      sample();
      check("wr_edit_gnt", {31'd0, e_gnt[0]}, 32'd1);
      next();
      idle();
      logic_req = 1'b1; logic_we = 1'b0; logic_addr = 16'h0010;
      sample();
      check("wr_mem_port", {6'd0, mem_en_v[0], mem_we_v[0], mem_addr_v[0], mem_wdata_v[0]},
            {6'd0, 1'b1, 1'b1, 16'h0010, 8'h5A});
      check("rd_logic_gnt", {31'd0, l_gnt[0]}, 32'd1);
      next();
      idle();
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         sample();
         if (l_rv[0]) begin
            found = 1'b1;
            check("wr_rd_data", {24'd0, rdata_v[0]}, 32'h5A);
            check("wr_rd_cycle", 32'(k), 32'd2);
         end
         next();
      end
      if (!found) check("wr_rd_timeout", 32'd0, 32'd1);
      idle_cycles(6);

      // Reads in flight, one-cycle reset pulse, then contention resumes.
      logic_req = 1'b1; edit_req = 1'b1; logic_addr = 16'h0020; edit_addr = 16'h0030;
      for (int i = 0; i < 3; i++) next();
      rst_in = 1'b1;
      sample();
      check("rst_pulse_gnt", {29'd0, r_gnt[0], l_gnt[0], e_gnt[0]}, 32'd0);
      check("rst_pulse_en", {31'd0, mem_en_v[0]}, 32'd0);
      next();
      rst_in = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         sample();
         if (j == 1)
            check("post_rst_logic_first", {29'd0, r_gnt[0], l_gnt[0], e_gnt[0]}, 32'd2);
         check($sformatf("flush_lat2[%0d]", j), {29'd0, r_rv[0], l_rv[0], e_rv[0]}, 32'd0);
         check($sformatf("flush_lat4[%0d]", j), {29'd0, r_rv[2], l_rv[2], e_rv[2]}, 32'd0);
         next();
      end
      idle_cycles(6);

      // Random traffic; logic/edit hold requests until granted.
      l_pend = 1'b0; e_pend = 1'b0;
      for (int i = 0; i < 400; i++) begin
         rst_in = ($urandom_range(0, 99) == 0);
         render_req = ($urandom_range(0, 3) == 0);
         render_addr = 16'($urandom_range(0, 15));
         if (!l_pend && $urandom_range(0, 1) == 1) begin
            l_pend = 1'b1;
            logic_we = 1'($urandom_range(0, 1));
            logic_addr = 16'($urandom_range(0, 15));
            logic_wdata = 8'($urandom);
         end
         if (!e_pend && $urandom_range(0, 1) == 1) begin
            e_pend = 1'b1;
            edit_we = 1'($urandom_range(0, 1));
            edit_addr = 16'($urandom_range(0, 15));
            edit_wdata = 8'($urandom);
         end
         logic_req = l_pend;
         edit_req = e_pend;
         sample();
         if (l_gnt[0]) l_pend = 1'b0;
         if (e_gnt[0]) e_pend = 1'b0;
         next();
      end
      rst_in = 1'b0;
      idle_cycles(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
